// File: rtl/truth_table_capture.sv
// Sweeps a 4-input function through all 16 vectors, captures its truth table, then streams
// the maxterm (zero) indices in ascending order. Optional golden compare: define TT_COMPARE_EN.
module truth_table_capture #(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] EXPECTED      = 16'hAC3C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  mt_count,
    output logic        mt_valid,
    input  logic        mt_ready,
    output logic [3:0]  mt_idx,
    output logic        mt_last,
`ifdef TT_COMPARE_EN
    output logic        mismatch,
    output logic [15:0] diff,
`endif
    output logic [2:0]  state_dbg
);

    // Handshake: an index transfers on a rising edge where mt_valid && mt_ready; while
    // mt_valid is high and mt_ready low, mt_idx and mt_last stay stable.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        DUMP   = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  vec;
    logic [3:0]  settle_cnt;
    logic [15:0] tbl_upd;
    logic [4:0]  cnt_upd;
    logic [4:0]  scan_from;
    logic [3:0]  next_zero;
    logic [3:0]  last_zero;

    function automatic logic [3:0] lowest_zero_from(input logic [15:0] t, input logic [4:0] from);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if ((5'(i) >= from) && !t[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] highest_zero(input logic [15:0] t);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (!t[i]) r = 4'(i);
        end
        return r;
    endfunction

    // The vector register drives the function inputs directly, so they are registered.
    assign {a, b, c, d} = vec;
    assign state_dbg    = state;

    always_comb begin
        tbl_upd      = table_out;
        tbl_upd[vec] = f_in;
    end

    assign cnt_upd   = mt_count + {4'd0, ~f_in};
    assign scan_from = mt_valid ? ({1'b0, mt_idx} + 5'd1) : 5'd0;
    assign next_zero = lowest_zero_from(table_out, scan_from);
    assign last_zero = highest_zero(table_out);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            mt_count   <= '0;
            mt_valid   <= 1'b0;
            mt_idx     <= '0;
            mt_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        table_out  <= '0;
                        mt_count   <= '0;
                        busy       <= 1'b1;
                        state      <= SKIP_SETTLE ? SAMPLE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_out <= tbl_upd;
                    mt_count  <= cnt_upd;
                    if (vec != 4'hF) begin
                        vec   <= vec + 4'd1;
                        state <= SKIP_SETTLE ? SAMPLE : SETTLE;
                    end else if (cnt_upd == 5'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        state <= DUMP;
                    end
                end
                DUMP: begin
                    // First DUMP cycle loads the lowest zero; each transfer loads the next one.
                    if (!mt_valid) begin
                        mt_valid <= 1'b1;
                        mt_idx   <= next_zero;
                        mt_last  <= (next_zero == last_zero);
                    end else if (mt_ready) begin
                        if (mt_last) begin
                            mt_valid <= 1'b0;
                            mt_last  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            mt_idx  <= next_zero;
                            mt_last <= (next_zero == last_zero);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TT_COMPARE_EN
    logic        fin_entry;
    logic [15:0] fin_table;

    // Results are latched on the edge entering FIN so they are visible with the done pulse.
    assign fin_entry = ((state == SAMPLE) && (vec == 4'hF) && (cnt_upd == 5'd0)) ||
                       ((state == DUMP) && mt_valid && mt_ready && mt_last);
    assign fin_table = (state == SAMPLE) ? tbl_upd : table_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            diff     <= '0;
            mismatch <= 1'b0;
        end else if ((state == IDLE) && start) begin
            diff     <= '0;
            mismatch <= 1'b0;
        end else if (fin_entry) begin
            diff     <= fin_table ^ EXPECTED;
            mismatch <= |(fin_table ^ EXPECTED);
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: directed sweeps with a queue-based maxterm scoreboard.
// Covers SETTLE_CYCLES=1 and SETTLE_CYCLES=0 instances; compare outputs checked under TT_COMPARE_EN.
module tb_truth_table_capture;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_DUMP   = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT with SETTLE_CYCLES=1 ----------------
    logic        start, f_in, mt_ready;
    logic        a, b, c, d, busy, done, mt_valid, mt_last;
    logic [15:0] table_out;
    logic [4:0]  mt_count;
    logic [3:0]  mt_idx;
    logic [2:0]  state_dbg;
`ifdef TT_COMPARE_EN
    logic        mismatch, mismatch0;
    logic [15:0] diff, diff0;
`endif

    truth_table_capture #(.SETTLE_CYCLES(1), .EXPECTED(16'hAC3C)) dut (
        .clk(clk), .reset(reset), .start(start), .f_in(f_in),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
        .table_out(table_out), .mt_count(mt_count),
        .mt_valid(mt_valid), .mt_ready(mt_ready), .mt_idx(mt_idx), .mt_last(mt_last),
`ifdef TT_COMPARE_EN
        .mismatch(mismatch), .diff(diff),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- DUT with SETTLE_CYCLES=0, f_in tied 0 ----------------
    logic        start0, mt_ready0;
    logic        f_in0;
    logic        a0, b0, c0, d0, busy0, done0, mt_valid0, mt_last0;
    logic [15:0] table_out0;
    logic [4:0]  mt_count0;
    logic [3:0]  mt_idx0;
    logic [2:0]  state_dbg0;

    assign f_in0 = 1'b0;

    truth_table_capture #(.SETTLE_CYCLES(0), .EXPECTED(16'hAC3C)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .f_in(f_in0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .table_out(table_out0), .mt_count(mt_count0),
        .mt_valid(mt_valid0), .mt_ready(mt_ready0), .mt_idx(mt_idx0), .mt_last(mt_last0),
`ifdef TT_COMPARE_EN
        .mismatch(mismatch0), .diff(diff0),
`endif
        .state_dbg(state_dbg0)
    );

    // ---------------- function-under-test model ----------------
    int          f_mode;       // 0: PoS(0,1,6,7,8,9,C,E), 1: tied 1, 2: tied 0
    logic [15:0] pos_fn;
    bit          toggle_ready;

    always_comb begin
        case (f_mode)
            0:       f_in = pos_fn[{a, b, c, d}];
            1:       f_in = 1'b1;
            default: f_in = 1'b0;
        endcase
    end

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp0_q[$];
    int xfer_cnt, valid_cnt, done_cnt, sweep_cycles;
    int xfer0_cnt, done0_cnt, sweep0_cycles;
    logic hold_pend, last_pend, last0_pend;
    logic [3:0] hold_idx;
    logic hold_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: main DUT ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (last_pend) check("done_after_last", 32'(done), 32'd1);
            last_pend = 1'b0;
            if (hold_pend) begin
                check("hold_valid", 32'(mt_valid), 32'd1);
                check("hold_idx", 32'(mt_idx), 32'(hold_idx));
                check("hold_last", 32'(mt_last), 32'(hold_last));
                hold_pend = 1'b0;
            end
            if (done) done_cnt++;
            if (mt_valid) valid_cnt++;
            if (state_dbg == ST_SETTLE || state_dbg == ST_SAMPLE) sweep_cycles++;
            if (mt_valid && mt_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got idx %0d expected no transfer", mt_idx);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("mt_idx", 32'(mt_idx), 32'(e));
                    check("mt_last", 32'(mt_last), 32'(exp_q.size() == 0));
                    if (mt_last) last_pend = 1'b1;
                end
            end else if (mt_valid) begin
                hold_pend = 1'b1;
                hold_idx  = mt_idx;
                hold_last = mt_last;
            end
        end
    end

    // ---------------- monitor: SETTLE_CYCLES=0 DUT ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (last0_pend) check("done0_after_last", 32'(done0), 32'd1);
            last0_pend = 1'b0;
            if (done0) done0_cnt++;
            if (state_dbg0 == ST_SETTLE || state_dbg0 == ST_SAMPLE) sweep0_cycles++;
            if (mt_valid0 && mt_ready0) begin
                xfer0_cnt++;
                if (exp0_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer0: got idx %0d expected no transfer", mt_idx0);
                end else begin
                    logic [3:0] e;
                    e = exp0_q.pop_front();
                    check("mt_idx0", 32'(mt_idx0), 32'(e));
                    check("mt_last0", 32'(mt_last0), 32'(exp0_q.size() == 0));
                    if (mt_last0) last0_pend = 1'b1;
                end
            end
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        mt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mt_ready = toggle_ready ? ~mt_ready : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_case(input string tag, input int mode, input bit tog, input bit glitch,
                            input logic [15:0] exp_tbl, input int exp_cnt);
        int base_done;
        f_mode       = mode;
        toggle_ready = tog;
        for (int i = 0; i < 16; i++) if (!exp_tbl[i]) exp_q.push_back(4'(i));
        base_done    = done_cnt;
        xfer_cnt     = 0;
        valid_cnt    = 0;
        sweep_cycles = 0;
        pulse_start();
        #2 check({tag, "_busy"}, 32'(busy), 32'd1);
        if (glitch) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            for (int n = 0; n < 200 && state_dbg != ST_DUMP; n++) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int n = 0; n < 1000 && done_cnt == base_done; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_table"}, 32'(table_out), 32'(exp_tbl));
        check({tag, "_mt_count"}, 32'(mt_count), 32'(exp_cnt));
        check({tag, "_xfers"}, 32'(xfer_cnt), 32'(exp_cnt));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_sweep_len"}, 32'(sweep_cycles), 32'd32);
        check({tag, "_abcd_hold"}, 32'({a, b, c, d}), 32'hF);
        if (mode == 1) check({tag, "_no_valid"}, 32'(valid_cnt), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int mt_list[8] = '{0, 1, 6, 7, 8, 9, 12, 14};
        int base_done;
        pos_fn = 16'hFFFF;
        foreach (mt_list[i]) pos_fn[mt_list[i]] = 1'b0;
        f_mode = 0; toggle_ready = 1'b0;
        start = 1'b0; start0 = 1'b0; mt_ready0 = 1'b1;
        done_cnt = 0; done0_cnt = 0; xfer0_cnt = 0; sweep0_cycles = 0;
        hold_pend = 1'b0; last_pend = 1'b0; last0_pend = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_outputs", 32'({a, b, c, d, busy, done, mt_valid, mt_last}), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_count_idx", 32'({mt_count, mt_idx}), 32'd0);
`ifdef TT_COMPARE_EN
        check("rst_compare", 32'({mismatch, diff}), 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_case("pos", 0, 1'b0, 1'b0, 16'hAC3C, 8);
`ifdef TT_COMPARE_EN
        check("pos_compare", 32'({mismatch, diff}), 32'd0);
`endif
        run_case("pos_toggle", 0, 1'b1, 1'b0, 16'hAC3C, 8);
        run_case("ones", 1, 1'b0, 1'b0, 16'hFFFF, 0);
`ifdef TT_COMPARE_EN
        check("ones_diff", 32'(diff), 32'h53C3);
        check("ones_mismatch", 32'(mismatch), 32'd1);
`endif

        // Asynchronous reset in SETTLE at vector 7 aborts without done.
        f_mode = 0; toggle_ready = 1'b0;
        base_done = done_cnt;
        pulse_start();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ({a, b, c, d} == 4'd7 && state_dbg == ST_SETTLE) break;
        end
        check("abort_reached_v7", 32'({a, b, c, d}), 32'd7);
        #2 reset = 1'b1;
        #1;
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        check("abort_outputs", 32'({a, b, c, d, busy, done, mt_valid, mt_last}), 32'd0);
        check("abort_table", 32'(table_out), 32'd0);
        check("abort_count_idx", 32'({mt_count, mt_idx}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_pend = 1'b0; last_pend = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
        run_case("post_abort", 0, 1'b0, 1'b0, 16'hAC3C, 8);

        run_case("start_glitch", 0, 1'b1, 1'b1, 16'hAC3C, 8);

        // Tied-0 function on the zero-settle instance.
        for (int i = 0; i < 16; i++) exp0_q.push_back(4'(i));
        base_done = done0_cnt;
        sweep0_cycles = 0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int n = 0; n < 500 && done0_cnt == base_done; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        check("zero_done_pulses", 32'(done0_cnt - base_done), 32'd1);
        check("zero_table", 32'(table_out0), 32'd0);
        check("zero_mt_count", 32'(mt_count0), 32'd16);
        check("zero_xfers", 32'(xfer0_cnt), 32'd16);
        check("zero_queue_left", 32'(exp0_q.size()), 32'd0);
        check("zero_sweep_len", 32'(sweep0_cycles), 32'd16);
        check("zero_abcd_hold", 32'({a0, b0, c0, d0}), 32'hF);
        check("zero_busy_after", 32'(busy0), 32'd0);
`ifdef TT_COMPARE_EN
        check("zero_diff", 32'(diff0), 32'hAC3C);
        check("zero_mismatch", 32'(mismatch0), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequential reader for a 4-input combinational function under test (SoP/PoS style blocks): drives inputs a,b,c,d through all 16 combinations, samples the function output, and builds the 16-bit truth table.
- After the sweep it streams the maxterm indices (entries where output = 0) in ascending order over a valid/ready handshake. This recovers the PoS(...) list from hardware.
- Sits beside the function block in a self-checking bench or on-board test harness.

Parameters:
- SETTLE_CYCLES, 1, clock cycles a vector is held before f_in is sampled (legal 0..15)
- EXPECTED, 16'hAC3C, golden truth table; bit i = f(abcd=i), a is MSB; used only with the optional feature

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin sweep; sampled in IDLE only
- f_in  input  1  output of the function under test
- a  output  1  input A to the function (index bit 3)
- b  output  1  input B (index bit 2)
- c  output  1  input C (index bit 1)
- d  output  1  input D (index bit 0)
- busy  output  1  high from the start edge until done
- done  output  1  one-cycle pulse when the dump completes
- table_out  output  16  captured truth table, bit i = f(i)
- mt_count  output  5  number of maxterms found (0..16)
- mt_valid  output  1  maxterm index valid
- mt_ready  input  1  consumer accepts index
- mt_idx  output  4  maxterm index
- mt_last  output  1  high with the final index

Behaviour:
- Reset (async, active-high): state IDLE; {a,b,c,d}=0; busy=0, done=0, table_out=0, mt_count=0, mt_valid=0, mt_idx=0, mt_last=0; internal vector and settle counters cleared. Reset mid-sweep or mid-dump aborts immediately with no partial done.
- States: IDLE, SETTLE, SAMPLE, DUMP, FIN.
- IDLE: start=1 at a clock edge -> vector=0, settle counter=0, table_out=0, mt_count=0, busy=1, go to SETTLE. start in any other state is ignored.
- SETTLE: {a,b,c,d}=vector, registered. Count SETTLE_CYCLES edges. When SETTLE_CYCLES=0, go straight to SAMPLE on the next edge.
- SAMPLE: on the edge leaving SAMPLE, table_out[vector] <= f_in; if f_in=0, mt_count increments.
  - vector<15: vector increments, go to SETTLE.
  - vector=15: go to DUMP, or to FIN if mt_count (including this sample) = 0.
- Sweep length: 16*(SETTLE_CYCLES+1) cycles.
- DUMP: scan indices 0..15 in ascending order and present each i with table_out[i]=0.
  - mt_valid=1, mt_idx=i; mt_last=1 when i is the highest zero index.
  - Transfer happens on an edge where mt_valid & mt_ready.
  - While valid & !ready, mt_idx and mt_last hold stable.
  - After the last transfer, go to FIN.
  - Skipping non-maxterm indices may cost idle cycles with mt_valid=0; at most one cycle per index.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- table_out and mt_count hold until the next start.
- {a,b,c,d} holds 4'hF after the sweep, until the next start or reset.
- mt_ready held high with an all-zero table: 16 transfers on consecutive-or-gapped cycles, mt_last with index 15, mt_count=16.
- f_in of x/z: sampled as-is (sim only); no special handling.

Optional Feature:
- Macro TT_COMPARE_EN.
- Defined:
  - Adds output mismatch (1 bit) and output diff (16 bits).
  - In FIN: diff = table_out ^ EXPECTED; mismatch = |diff.
  - Both valid from the done pulse and held until the next start. Reset clears both to 0.
- Undefined: neither port exists; no comparison logic.

Test Plan:
- f_in driven by a model of PoS(0,1,6,7,8,9,C,E), SETTLE_CYCLES=1, mt_ready=1 -> table_out=16'hAC3C, mt_count=8, indices 0,1,6,7,8,9,12,14 streamed, mt_last with 14, done one cycle later. With TT_COMPARE_EN: mismatch=0.
- Same stimulus with mt_ready toggling 1/0 every cycle -> each index held stable while not ready; same 8 indices in order, no duplicates or drops.
- f_in tied 1 -> table_out=16'hFFFF, mt_count=0, mt_valid never asserts, done after the sweep.
- f_in tied 0, SETTLE_CYCLES=0 -> sweep takes 16 cycles, 16 indices 0..15, mt_last with 15, mt_count=16. With TT_COMPARE_EN: diff=16'hAC3C, mismatch=1.
- Reset asserted asynchronously at vector=7 during SETTLE -> all outputs return to reset values immediately, no done. A new start then produces the full correct result.
- start pulsed during the sweep and during DUMP -> ignored; results identical to an undisturbed run.
